// File: rtl/vend_pkg.sv
// Shared vending definitions: coin values, denomination indices, payout FSM
// states and coin <-> index helpers. Also used by the coin acceptor side.
package vend_pkg;

    localparam logic [7:0] COIN_10  = 8'd10;
    localparam logic [7:0] COIN_20  = 8'd20;
    localparam logic [7:0] COIN_50  = 8'd50;
    localparam logic [7:0] COIN_100 = 8'd100;
    localparam logic [7:0] COIN_200 = 8'd200;

    localparam int NUM_DENOM = 5;

    typedef enum logic [2:0] {
        D10  = 3'd0,
        D20  = 3'd1,
        D50  = 3'd2,
        D100 = 3'd3,
        D200 = 3'd4
    } denom_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PICK  = 3'd1,
        ST_OFFER = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIN   = 3'd4
    } payout_state_t;

    function automatic logic [7:0] idx_to_coin(input denom_idx_t idx);
        case (idx)
            D10:     return COIN_10;
            D20:     return COIN_20;
            D50:     return COIN_50;
            D100:    return COIN_100;
            D200:    return COIN_200;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic is_valid_coin(input logic [7:0] coin);
        return (coin == COIN_10) || (coin == COIN_20) || (coin == COIN_50) ||
               (coin == COIN_100) || (coin == COIN_200);
    endfunction

    // Non-denomination values map to D10; callers gate with is_valid_coin().
    function automatic denom_idx_t coin_to_idx(input logic [7:0] coin);
        case (coin)
            COIN_20:  return D20;
            COIN_50:  return D50;
            COIN_100: return D100;
            COIN_200: return D200;
            default:  return D10;
        endcase
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin stock: saturating counters with a refill increment
// port and a payout decrement port. A refill and a payout of the same
// denomination in one cycle cancel out.
module coin_inventory
    import vend_pkg::*;
#(
    parameter int INV_W      = 4,
    parameter int INIT_COUNT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 refill_valid,
    input  logic [7:0]           refill_coin,
    input  logic                 dec_valid,
    input  denom_idx_t           dec_idx,
    output logic [NUM_DENOM-1:0] empty_flags
);

    localparam logic [INV_W-1:0] CNT_MAX  = '1;
    localparam logic [INV_W-1:0] CNT_INIT = INV_W'(INIT_COUNT);

    logic [INV_W-1:0]     count [NUM_DENOM];
    logic [NUM_DENOM-1:0] inc_vec;
    logic [NUM_DENOM-1:0] dec_vec;

    // Decode refill and payout strobes into one-hot per-denomination requests.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (refill_valid && is_valid_coin(refill_coin)) begin
            inc_vec[coin_to_idx(refill_coin)] = 1'b1;
        end
        if (dec_valid) begin
            dec_vec[dec_idx] = 1'b1;
        end
    end

    // Counter update; the payout side never decrements an empty counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DENOM; i++) begin
                count[i] <= CNT_INIT;
            end
        end else begin
            for (int i = 0; i < NUM_DENOM; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    if (count[i] != CNT_MAX) begin
                        count[i] <= count[i] + 1'b1;
                    end
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
        end
    end

    // Empty indication per denomination.
    always_comb begin
        for (int i = 0; i < NUM_DENOM; i++) begin
            empty_flags[i] = (count[i] == '0);
        end
    end

endmodule

// File: rtl/coin_payout.sv
// Change dispenser: pays a requested amount as single coins, largest
// available denomination first, one coin per hopper handshake.
// Optional build macro COIN_PAYOUT_TIMEOUT_EN adds an offer timeout that
// abandons the request (done + short_err) when the hopper stalls.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a change request, req_ready high
// ST_PICK  | choose largest coin <= remaining with stock, or finish
// ST_OFFER | coin_valid high, coin_out held until hopper takes it
// ST_GAP   | idle cycles after a taken coin before the next pick
// ST_FIN   | one-cycle done pulse, short_err if residue is left
module coin_payout
    import vend_pkg::*;
#(
    parameter int INV_W      = 4,
    parameter int INIT_COUNT = 8,
    parameter int GAP        = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           req_amount,
    output logic                 coin_valid,
    input  logic                 coin_ready,
    output logic [7:0]           coin_out,
    input  logic                 refill_valid,
    input  logic [7:0]           refill_coin,
    output logic                 done,
    output logic                 short_err,
    output logic [7:0]           remaining,
    output logic [NUM_DENOM-1:0] empty_flags
);

    // One width serves both the gap and timeout down-counters.
    localparam int CNT_W = $clog2(((GAP > TIMEOUT) ? GAP : TIMEOUT) + 1);

    payout_state_t    state, state_nxt;
    logic [7:0]       coin_q;
    denom_idx_t       sel_q;
    denom_idx_t       pick_idx;
    logic             pick_found;
    logic             handshake;
    logic [CNT_W-1:0] gap_cnt;
`ifdef COIN_PAYOUT_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt;
`endif

    coin_inventory #(
        .INV_W      (INV_W),
        .INIT_COUNT (INIT_COUNT)
    ) u_inv (
        .clk          (clk),
        .rst          (rst),
        .refill_valid (refill_valid),
        .refill_coin  (refill_coin),
        .dec_valid    (handshake),
        .dec_idx      (sel_q),
        .empty_flags  (empty_flags)
    );

    // Greedy picker: later (larger) qualifying denominations override earlier ones.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = D10;
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (!empty_flags[i] && (idx_to_coin(denom_idx_t'(3'(i))) <= remaining)) begin
                pick_found = 1'b1;
                pick_idx   = denom_idx_t'(3'(i));
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        coin_valid = 1'b0;
        handshake  = 1'b0;
        done       = 1'b0;
        short_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_PICK;
            end
            ST_PICK: begin
                if ((remaining == 8'd0) || !pick_found) state_nxt = ST_FIN;
                else                                    state_nxt = ST_OFFER;
            end
            ST_OFFER: begin
                coin_valid = 1'b1;
                if (coin_ready) begin
                    handshake = 1'b1;
                    state_nxt = (GAP > 0) ? ST_GAP : ST_PICK;
                end
`ifdef COIN_PAYOUT_TIMEOUT_EN
                else if (to_cnt == '0) begin
                    state_nxt = ST_FIN;
                end
`endif
            end
            ST_GAP: begin
                if (gap_cnt == '0) state_nxt = ST_PICK;
            end
            ST_FIN: begin
                done      = 1'b1;
                short_err = (remaining != 8'd0);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign coin_out = coin_valid ? coin_q : 8'd0;

    // Datapath: residue, latched selection and the down-counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= 8'd0;
            coin_q    <= 8'd0;
            sel_q     <= D10;
            gap_cnt   <= '0;
`ifdef COIN_PAYOUT_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) remaining <= req_amount;
                end
                ST_PICK: begin
                    coin_q <= idx_to_coin(pick_idx);
                    sel_q  <= pick_idx;
`ifdef COIN_PAYOUT_TIMEOUT_EN
                    to_cnt <= CNT_W'(TIMEOUT - 1);
`endif
                end
                ST_OFFER: begin
                    if (handshake) begin
                        remaining <= remaining - coin_q;
                        gap_cnt   <= CNT_W'(GAP - 1);
                    end
`ifdef COIN_PAYOUT_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
`endif
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_payout.sv
// Self-checking bench for coin_payout. Expected coins come from a greedy
// inventory model and are queued when a request is issued, then popped as
// the DUT offers each coin. Covers COIN_PAYOUT_TIMEOUT_EN when defined.
module tb_coin_payout;
    import vend_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_amount = 8'd0;
    logic       coin_valid;
    logic       coin_ready = 1'b0;
    logic [7:0] coin_out;
    logic       refill_valid = 1'b0;
    logic [7:0] refill_coin = 8'd0;
    logic       done;
    logic       short_err;
    logic [7:0] remaining;
    logic [4:0] empty_flags;

    int checks   = 0;
    int failures = 0;

    int         inv_m [5];
    int         coin_val [5] = '{10, 20, 50, 100, 200};
    logic [7:0] exp_q [$];

    coin_payout dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_amount   (req_amount),
        .coin_valid   (coin_valid),
        .coin_ready   (coin_ready),
        .coin_out     (coin_out),
        .refill_valid (refill_valid),
        .refill_coin  (refill_coin),
        .done         (done),
        .short_err    (short_err),
        .remaining    (remaining),
        .empty_flags  (empty_flags)
    );

    always #5 clk = ~clk;

    function automatic int coin_index(input logic [7:0] c);
        for (int i = 0; i < 5; i++) if (int'(c) == coin_val[i]) return i;
        return -1;
    endfunction

    task automatic model_refill(input logic [7:0] c);
        int idx;
        idx = coin_index(c);
        if (idx >= 0 && inv_m[idx] < 15) inv_m[idx]++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        coin_ready = 1'b0;
        refill_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) inv_m[i] = 8;
        exp_q.delete();
    endtask

    // Issue one request and play the hopper; rdy_delay stall cycles per coin,
    // optional refill during the first stall cycle and at each handshake.
    task automatic do_request(input logic [7:0] amt, input int rdy_delay,
                              input logic [7:0] wait_refill, input logic [7:0] hs_refill);
        int  rem;
        int  waited;
        bit  fin;
        bit  go;
        logic [7:0] exp_c;
        rem = int'(amt);
        go  = 1'b1;
        while (go && rem != 0) begin
            go = 1'b0;
            for (int d = 4; d >= 0; d--) begin
                if (!go && inv_m[d] > 0 && coin_val[d] <= rem) begin
                    go = 1'b1;
                    exp_q.push_back(8'(coin_val[d]));
                    rem -= coin_val[d];
                    inv_m[d]--;
                end
            end
        end

        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_ready_idle: got %b expected 1", req_ready);
        end
        req_valid  = 1'b1;
        req_amount = amt;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (coin_valid !== 1'b0 || done !== 1'b0 || remaining !== amt || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL pick_cycle: got valid=%b done=%b rem=%0d ready=%b expected 0 0 %0d 0",
                     coin_valid, done, remaining, req_ready, amt);
        end

        waited = 0;
        fin    = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            @(negedge clk);
            coin_ready   = 1'b0;
            refill_valid = 1'b0;
            if (cyc == 0) begin
                checks++;
                if ((coin_valid | done) !== 1'b1) begin
                    failures++;
                    $display("FAIL latency: got valid=%b done=%b at accept+2, expected one high",
                             coin_valid, done);
                end
            end
            if (done === 1'b1) begin
                fin = 1'b1;
                checks++;
                if (short_err !== (rem != 0) || int'(remaining) != rem || exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL done_status: got short=%b rem=%0d pending=%0d expected short=%b rem=%0d pending=0",
                             short_err, remaining, exp_q.size(), (rem != 0), rem);
                end
            end else if (coin_valid === 1'b1) begin
                exp_c = (exp_q.size() > 0) ? exp_q[0] : 8'd0;
                checks++;
                if (coin_out !== exp_c) begin
                    failures++;
                    $display("FAIL coin_out: got %0d expected %0d", coin_out, exp_c);
                end
                if (waited < rdy_delay) begin
                    waited++;
                    if (waited == 1 && wait_refill != 8'd0) begin
                        refill_valid = 1'b1;
                        refill_coin  = wait_refill;
                        model_refill(wait_refill);
                    end
                end else begin
                    coin_ready = 1'b1;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    waited = 0;
                    if (hs_refill != 8'd0) begin
                        refill_valid = 1'b1;
                        refill_coin  = hs_refill;
                        model_refill(hs_refill);
                    end
                end
            end else begin
                checks++;
                if (coin_out !== 8'd0) begin
                    failures++;
                    $display("FAIL coin_out_idle: got %0d expected 0", coin_out);
                end
            end
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL request_timeout: got no done for amount %0d expected done", amt);
        end
        coin_ready   = 1'b0;
        refill_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (req_ready !== 1'b1 || coin_valid !== 1'b0 || coin_out !== 8'd0 || done !== 1'b0 ||
            short_err !== 1'b0 || remaining !== 8'd0 || empty_flags !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b val=%b out=%0d done=%b se=%b rem=%0d ef=%b expected 1 0 0 0 0 0 00000",
                     req_ready, coin_valid, coin_out, done, short_err, remaining, empty_flags);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (int'(dut.u_inv.count[i]) != 8) begin
                failures++;
                $display("FAIL reset_inv%0d: got %0d expected 8", i, dut.u_inv.count[i]);
            end
        end
    endtask

    task automatic test_greedy();
        do_request(8'd80, 0, 8'd0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (int'(dut.u_inv.count[i]) != ((i < 3) ? 7 : 8)) begin
                failures++;
                $display("FAIL greedy_inv%0d: got %0d expected %0d", i, dut.u_inv.count[i], (i < 3) ? 7 : 8);
            end
        end
        do_request(8'd25, 0, 8'd0, 8'd0);
        do_request(8'd30, 0, 8'd0, 8'd0);
        do_request(8'd0, 0, 8'd0, 8'd0);
    endtask

    task automatic test_drain();
        do_reset();
        for (int k = 0; k < 8; k++) do_request(8'd10, 0, 8'd0, 8'd0);
        do_request(8'd30, 0, 8'd0, 8'd0);
        checks++;
        if (remaining !== 8'd10 || empty_flags !== 5'b00001) begin
            failures++;
            $display("FAIL drain_state: got rem=%0d ef=%b expected rem=10 ef=00001", remaining, empty_flags);
        end
    endtask

    task automatic test_stall_refill();
        do_reset();
        do_request(8'd20, 5, COIN_200, 8'd0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (int'(dut.u_inv.count[i]) != inv_m[i]) begin
                failures++;
                $display("FAIL stall_inv%0d: got %0d expected %0d", i, dut.u_inv.count[i], inv_m[i]);
            end
        end
    endtask

    task automatic test_same_cycle_refill();
        do_reset();
        do_request(8'd10, 0, 8'd0, COIN_10);
        @(negedge clk);
        refill_valid = 1'b1;
        refill_coin  = 8'd37;
        @(negedge clk);
        refill_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (int'(dut.u_inv.count[i]) != inv_m[i]) begin
                failures++;
                $display("FAIL refill_inv%0d: got %0d expected %0d", i, dut.u_inv.count[i], inv_m[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        refill_valid = 1'b1;
        refill_coin  = COIN_200;
        for (int k = 0; k < 8; k++) begin
            model_refill(COIN_200);
            @(negedge clk);
        end
        refill_valid = 1'b0;
        checks++;
        if (int'(dut.u_inv.count[4]) != 15) begin
            failures++;
            $display("FAIL saturate_inv200: got %0d expected 15", dut.u_inv.count[4]);
        end
        do_request(8'd200, 0, 8'd0, 8'd0);
        do_request(8'd240, 0, 8'd0, 8'd0);
    endtask

    task automatic test_stall_mode();
`ifdef COIN_PAYOUT_TIMEOUT_EN
        int vcyc;
        bit fin;
        do_reset();
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 8'd50;
        @(negedge clk);
        req_valid = 1'b0;
        vcyc = 0;
        fin  = 1'b0;
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            @(negedge clk);
            if (coin_valid === 1'b1) vcyc++;
            if (done === 1'b1) begin
                fin = 1'b1;
                checks++;
                if (short_err !== 1'b1 || remaining !== 8'd50 || vcyc != 16) begin
                    failures++;
                    $display("FAIL timeout_done: got se=%b rem=%0d offer_cycles=%0d expected 1 50 16",
                             short_err, remaining, vcyc);
                end
            end
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL timeout_wait: got no done expected done after 16 stall cycles");
        end
        checks++;
        if (int'(dut.u_inv.count[2]) != 8) begin
            failures++;
            $display("FAIL timeout_inv50: got %0d expected 8", dut.u_inv.count[2]);
        end
`else
        do_reset();
        do_request(8'd50, 20, 8'd0, 8'd0);
`endif
    endtask

    task automatic test_reset_mid_offer();
        bit seen;
        do_reset();
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 8'd50;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            if (coin_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL mid_offer_reach: got coin_valid=0 expected 1");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (coin_valid !== 1'b0 || req_ready !== 1'b1 || coin_out !== 8'd0 || int'(dut.u_inv.count[2]) != 8) begin
            failures++;
            $display("FAIL mid_offer_reset: got val=%b rdy=%b out=%0d inv50=%0d expected 0 1 0 8",
                     coin_valid, req_ready, coin_out, dut.u_inv.count[2]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) inv_m[i] = 8;
        exp_q.delete();
        do_request(8'd80, 0, 8'd0, 8'd0);
    endtask

    initial begin
        test_reset();
        test_greedy();
        test_drain();
        test_stall_refill();
        test_same_cycle_refill();
        test_back_to_back();
        test_stall_mode();
        test_reset_mid_offer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
